// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization leaf controller.
// Holds the controller state encoding and the response status codes.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    ERROR   = 2'b01,
    TIMEOUT = 2'b10
  } sync_status_e;

  localparam int unsigned STATUS_WIDTH = 2;

endpackage

// File: rtl/fractal_sync_ctrl_if.sv
// Bundles the request/response channels, status flags and the sync master port.
// The slave modport is the controller's view; the master modport is the environment's view.
interface fractal_sync_ctrl_if #(
  parameter int unsigned AGGR_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned SD_WIDTH   = 2
);
  import fractal_sync_pkg::*;

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AGGR_WIDTH-1:0]   req_aggr_i;
  logic [ID_WIDTH-1:0]     req_id_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [STATUS_WIDTH-1:0] rsp_status_o;
  logic                    busy_o;
  logic                    stray_o;
  logic                    sync_o;
  logic [AGGR_WIDTH-1:0]   aggr_o;
  logic [ID_WIDTH-1:0]     id_o;
  logic [SD_WIDTH-1:0]     src_o;
  logic                    wake_i;
  logic [SD_WIDTH-1:0]     dst_i;
  logic                    error_i;

  modport slave (
    input  req_valid_i, req_aggr_i, req_id_i, rsp_ready_i, wake_i, dst_i, error_i,
    output req_ready_o, rsp_valid_o, rsp_status_o, busy_o, stray_o,
           sync_o, aggr_o, id_o, src_o
  );

  modport master (
    output req_valid_i, req_aggr_i, req_id_i, rsp_ready_i, wake_i, dst_i, error_i,
    input  req_ready_o, rsp_valid_o, rsp_status_o, busy_o, stray_o,
           sync_o, aggr_o, id_o, src_o
  );

endinterface

// File: rtl/fractal_sync_ctrl_timeout_cnt.sv
// Saturating WAIT-cycle counter; a zero limit disables expiry entirely.
module fractal_sync_timeout_cnt #(
  parameter int unsigned CNT_WIDTH = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic                 expired_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 disabled;

  assign disabled  = (limit_i == '0);
  assign expired_o = !disabled && (cnt_q >= limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !disabled && !expired_o) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fractal_sync_ctrl.sv
// Leaf-side sequencer: accepts one barrier request, issues it on the sync port,
// waits for wake/error with a bounded timeout and returns a status response.
module fractal_sync_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int unsigned          AGGR_WIDTH     = 4,
  parameter int unsigned          ID_WIDTH       = 2,
  parameter int unsigned          SD_WIDTH       = 2,
  parameter logic [SD_WIDTH-1:0]  LOCAL_SD       = 2'b01,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  localparam int unsigned         CNT_WIDTH      = (TIMEOUT_CYCLES > 0) ?
                                                   $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  fractal_sync_ctrl_if.slave bus
);

  ctrl_state_e           state_q, state_d;
  sync_status_e          status_q, status_d;
  logic [AGGR_WIDTH-1:0] aggr_q, aggr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  stray_q, stray_d;

  logic accept;
  logic legal;
  logic dst_match;
  logic tree_event;
  logic expired;

  assign accept     = bus.req_valid_i && (state_q == IDLE);
  assign legal      = accept && (bus.req_aggr_i != '0);
  assign dst_match  = (bus.dst_i & LOCAL_SD) != '0;
  assign tree_event = bus.wake_i || bus.error_i;

  fractal_sync_timeout_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (legal),
    .enable_i  (state_q == WAIT),
    .limit_i   (CNT_WIDTH'(TIMEOUT_CYCLES)),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    aggr_d   = aggr_q;
    id_d     = id_q;
    stray_d  = stray_q;

    unique case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = SYNC;
          aggr_d  = bus.req_aggr_i;
          id_d    = bus.req_id_i;
          stray_d = 1'b0;
        end else if (accept) begin
          state_d  = RESP;
          status_d = ERROR;
        end
        // An event landing in the accept cycle still belongs to no barrier.
        if (tree_event) begin
          stray_d = 1'b1;
        end
      end
      SYNC: begin
        state_d = WAIT;
        if (tree_event) begin
          stray_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.error_i) begin
          state_d  = RESP;
          status_d = ERROR;
        end else if (bus.wake_i && dst_match) begin
          state_d  = RESP;
          status_d = OK;
        end else begin
          if (bus.wake_i) begin
            stray_d = 1'b1;
          end
          if (expired) begin
            state_d  = RESP;
            status_d = TIMEOUT;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
        if (tree_event) begin
          stray_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      status_q <= OK;
      aggr_q   <= '0;
      id_q     <= '0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      aggr_q   <= aggr_d;
      id_q     <= id_d;
      stray_q  <= stray_d;
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_status_o = status_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.stray_o      = stray_q;
  assign bus.sync_o       = (state_q == SYNC);
  assign bus.aggr_o       = aggr_q;
  assign bus.id_o         = id_q;
  assign bus.src_o        = LOCAL_SD;

endmodule

// File: tb/tb_fractal_sync_ctrl.sv
// Directed self-checking bench for fractal_sync_ctrl with a short timeout (8 cycles).
module tb_fractal_sync_ctrl;

  localparam int unsigned AGGR_W = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned SD_W   = 2;

  logic clk_i;
  logic rst_ni;
  int   checkCount;
  int   errorCount;

  fractal_sync_ctrl_if #(
    .AGGR_WIDTH (AGGR_W),
    .ID_WIDTH   (ID_W),
    .SD_WIDTH   (SD_W)
  ) bus ();

  fractal_sync_ctrl #(
    .AGGR_WIDTH     (AGGR_W),
    .ID_WIDTH       (ID_W),
    .SD_WIDTH       (SD_W),
    .LOCAL_SD       (2'b01),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] aggr, input logic [1:0] id,
                               input logic wake, input logic [1:0] dst, input logic err,
                               input logic rspReady);
    bus.req_valid_i = valid;
    bus.req_aggr_i  = aggr;
    bus.req_id_i    = id;
    bus.wake_i      = wake;
    bus.dst_i       = dst;
    bus.error_i     = err;
    bus.rsp_ready_i = rspReady;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    checkOutput({tag, "_status"},    32'(bus.rsp_status_o), 32'd0);
    checkOutput({tag, "_busy"},      32'(bus.busy_o), 32'd0);
    checkOutput({tag, "_stray"},     32'(bus.stray_o), 32'd0);
    checkOutput({tag, "_sync"},      32'(bus.sync_o), 32'd0);
    checkOutput({tag, "_aggr"},      32'(bus.aggr_o), 32'd0);
    checkOutput({tag, "_id"},        32'(bus.id_o), 32'd0);
    checkOutput({tag, "_src"},       32'(bus.src_o), 32'd1);
  endtask

  // Consume a pending response with one handshake cycle.
  task automatic finishResponse(input string tag);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput({tag, "_back_idle"}, 32'(bus.req_ready_o), 32'd1);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_ni = 1'b0;
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checkResetValues("reset");
    rst_ni = 1'b1;
    tick();

    // Basic barrier: accept at t0, sync at t1, wake at t5, response at t6.
    applyStimulus(1'b1, 4'b0010, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("basic_sync", 32'(bus.sync_o), 32'd1);
    checkOutput("basic_aggr", 32'(bus.aggr_o), 32'h2);
    checkOutput("basic_id",   32'(bus.id_o), 32'd1);
    checkOutput("basic_src",  32'(bus.src_o), 32'd1);
    checkOutput("basic_req_ready_busy", 32'(bus.req_ready_o), 32'd0);
    tick();
    checkOutput("basic_sync_one_cycle", 32'(bus.sync_o), 32'd0);
    checkOutput("basic_busy_wait", 32'(bus.busy_o), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("basic_no_rsp_yet", 32'(bus.rsp_valid_o), 32'd0);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("basic_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    checkOutput("basic_status",    32'(bus.rsp_status_o), 32'd0);
    checkOutput("basic_aggr_hold", 32'(bus.aggr_o), 32'h2);
    finishResponse("basic");
    checkOutput("basic_aggr_kept_idle", 32'(bus.aggr_o), 32'h2);

    // Error wins over a simultaneous matching wake and is not a stray.
    applyStimulus(1'b1, 4'b0100, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b11, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("errprio_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    checkOutput("errprio_status",    32'(bus.rsp_status_o), 32'd1);
    checkOutput("errprio_stray",     32'(bus.stray_o), 32'd0);
    finishResponse("errprio");

    // Timeout: WAIT entered at w, response visible at w+9.
    applyStimulus(1'b1, 4'b1000, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    repeat (8) tick();
    checkOutput("timeout_not_yet", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    checkOutput("timeout_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    checkOutput("timeout_status",    32'(bus.rsp_status_o), 32'd2);
    finishResponse("timeout");
    checkOutput("timeout_stray_before", 32'(bus.stray_o), 32'd0);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("timeout_late_wake_stray", 32'(bus.stray_o), 32'd1);
    checkOutput("timeout_late_wake_idle",  32'(bus.busy_o), 32'd0);

    // Illegal request: no sync pulse, ERROR response directly.
    applyStimulus(1'b1, 4'b0000, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("illegal_no_sync",   32'(bus.sync_o), 32'd0);
    checkOutput("illegal_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    checkOutput("illegal_status",    32'(bus.rsp_status_o), 32'd1);
    checkOutput("illegal_aggr_kept", 32'(bus.aggr_o), 32'h8);
    finishResponse("illegal");

    // Destination filter: dst=10 is a stray, dst=01 completes.
    applyStimulus(1'b1, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("dst_stray_cleared", 32'(bus.stray_o), 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("dst_mismatch_stray", 32'(bus.stray_o), 32'd1);
    checkOutput("dst_mismatch_wait",  32'(bus.rsp_valid_o), 32'd0);
    checkOutput("dst_mismatch_busy",  32'(bus.busy_o), 32'd1);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("dst_match_rsp",    32'(bus.rsp_valid_o), 32'd1);
    checkOutput("dst_match_status", 32'(bus.rsp_status_o), 32'd0);
    finishResponse("dst");

    // Backpressure: response held for 10 cycles while a second request waits.
    applyStimulus(1'b1, 4'b0010, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0100, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      checkOutput("bp_status",    32'(bus.rsp_status_o), 32'd0);
      checkOutput("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 4'b0100, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("bp_idle_after_hs", 32'(bus.busy_o), 32'd0);
    checkOutput("bp_no_sync",       32'(bus.sync_o), 32'd0);
    checkOutput("bp_aggr_not_taken", 32'(bus.aggr_o), 32'h2);
    tick();
    checkOutput("bp_still_idle", 32'(bus.busy_o), 32'd0);

    // Reset in WAIT abandons the barrier; a later wake is a stray.
    applyStimulus(1'b1, 4'b0100, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    checkResetValues("midreset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("midreset_late_wake_stray", 32'(bus.stray_o), 32'd1);
    applyStimulus(1'b1, 4'b1000, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("midreset_sync", 32'(bus.sync_o), 32'd1);
    checkOutput("midreset_aggr", 32'(bus.aggr_o), 32'h8);
    checkOutput("midreset_id",   32'(bus.id_o), 32'd3);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    checkOutput("midreset_status",    32'(bus.rsp_status_o), 32'd0);
    finishResponse("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
